priority_scan_encoder: RTL
==========================

# priority_scan_encoder

Parametrised, sequential successor to the team's 16-bit combinational priority encoder. Captures a WIDTH-bit request vector through a valid/ready input handshake, then emits the index of every set bit, one per accepted output beat, in priority order. The order is MSB-first or LSB-first by parameter. Sits between request-collection logic and any consumer that must service all pending requests in priority order, not just the winner.

## Interface
- WIDTH, 16: request vector width, ≥2; need not be a power of two.
- MSB_FIRST, 1: 1 = highest set index emitted first; 0 = lowest set index first.
- IDX_W (localparam) = $clog2(WIDTH): index width.

- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- abort  in  1  synchronous scan cancel; sampled on rising clk.
- in_valid  in  1  in_vec is valid.
- in_ready  out  1  block can accept a vector.
- in_vec  in  WIDTH  request vector.
- out_valid  out  1  out_idx/out_last/out_none are valid.
- out_ready  in  1  consumer accepts current beat.
- out_idx  out  IDX_W  index of current highest-priority pending bit.
- out_last  out  1  current beat is final for this vector.
- out_none  out  1  captured vector was all zeros.
- busy  out  1  scan in progress (state SCAN).

## Operation
- Two states: IDLE, SCAN. Internal WIDTH-bit pending register.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: pending←in_vec, zero_flag←(in_vec==0), go SCAN.
- SCAN:
  - in_ready=0, out_valid=1.
  - out_idx = priority index of pending: highest set bit if MSB_FIRST=1, lowest if 0.
  - out_last=1 when pending has ≤1 bit set.
  - out_none=zero_flag.
  - Zero vector: a single beat with out_idx=0, out_none=1, out_last=1.
- Output beat transfer: out_valid&&out_ready.
  - Clear pending bit out_idx.
  - If out_last, go IDLE.
  - Otherwise stay in SCAN; the next index appears next cycle.
- abort=1 in any state: next state IDLE, pending←0, zero_flag←0. Takes priority over the transfer and the capture in the same cycle; any beat presented that cycle counts as not transferred.
- out_idx, out_last, out_none are derived only from registers (pending, zero_flag, state). There is no combinational path from any input to any output except through a state change at a clock edge.
- Outputs while out_valid=0: out_idx=0, out_last=0, out_none=0.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, pending=0, zero_flag=0.
  - Output values during reset: in_ready=1, out_valid=0, out_idx=0, out_last=0, out_none=0, busy=0.
- Reset mid-scan drops all remaining beats immediately. There is no partial output after reset deasserts.
- Latency: vector accepted at edge N → first beat valid in the cycle after edge N.
- Throughput:
  - With out_ready held high, one index per cycle. A vector with K set bits occupies SCAN for max(K,1) cycles.
  - In_ready returns high the cycle after the last beat transfers. Minimum spacing between accepted vectors is max(K,1)+1 cycles.
- Backpressure: while out_valid=1 and out_ready=0, out_idx, out_last and out_none stay stable and pending is unchanged.
- in_valid is ignored while in_ready=0. in_vec is don't-care except at the capture edge.
- Full-ones vector emits all WIDTH indices.
- Non-power-of-two WIDTH: out_idx never exceeds WIDTH-1.

## Test plan
- WIDTH=16, MSB_FIRST=1, out_ready=1, in_vec=0x8421 → out_idx 15,10,5,0 on consecutive cycles, out_last=1 only with 0. in_ready high again on the following cycle.
- Same configuration, MSB_FIRST=0, in_vec=0x8421 → out_idx 0,5,10,15, out_last=1 only with 15.
- in_vec=0x0000 → one beat: out_idx=0, out_none=1, out_last=1. Then back to IDLE.
- in_vec=0x0003 (MSB_FIRST=1), out_ready low for 3 cycles after out_valid rises → out_idx=1 held stable for those 3 cycles, then 1, 0 once out_ready rises.
- in_vec=0xFFFF, abort pulsed on the 3rd beat → beats 15,14 transfer, nothing further. in_ready=1 next cycle. A new vector 0x0100 yields a single beat idx=8, last=1.
- WIDTH=5, in_vec=5'b10010, and rst_n pulsed low after the first beat → IDX_W=3, first out_idx=4. Outputs reset immediately. After reset, out_valid stays 0 until a new capture.

Source files
------------

// File: rtl/priority_scan_encoder.sv
// rtl/priority_scan_encoder.sv - captures a request vector and emits each set index in priority order
module priority_scan_encoder #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1,
    localparam int IDX_W    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_none,
    output logic             busy
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] pending, pending_nx;
    logic             zero_flag, zero_flag_nx;
    logic [IDX_W-1:0] prio_idx;
    logic             at_most_one;

    // Later iterations overwrite earlier ones, so loop direction selects the winner.
    always_comb begin
        prio_idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (pending[i]) prio_idx = IDX_W'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (pending[i]) prio_idx = IDX_W'(i);
            end
        end
    end

    assign at_most_one = ((pending & (pending - WIDTH'(1))) == '0);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == SCAN);
    assign busy      = (state == SCAN);
    assign out_idx   = out_valid ? prio_idx : '0;
    assign out_last  = out_valid && at_most_one;
    assign out_none  = out_valid && zero_flag;

    always_comb begin
        state_nx     = state;
        pending_nx   = pending;
        zero_flag_nx = zero_flag;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    pending_nx   = in_vec;
                    zero_flag_nx = (in_vec == '0);
                    state_nx     = SCAN;
                end
            end
            SCAN: begin
                if (out_ready) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (IDX_W'(i) == prio_idx) pending_nx[i] = 1'b0;
                    end
                    if (at_most_one) begin
                        state_nx     = IDLE;
                        zero_flag_nx = 1'b0;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        // Cancel wins over both capture and beat transfer in the same cycle.
        if (abort) begin
            state_nx     = IDLE;
            pending_nx   = '0;
            zero_flag_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= '0;
            zero_flag <= 1'b0;
        end else begin
            state     <= state_nx;
            pending   <= pending_nx;
            zero_flag <= zero_flag_nx;
        end
    end

endmodule
